// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave.
package i2c_pkg;

  localparam int   BIT_CNT_W = 3;
  localparam logic I2C_ACK   = 1'b0;
  localparam logic I2C_NACK  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes scl/sda into clk and detects SCL edges plus START/STOP.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_d;
  logic       sda_d;
  logic [1:0] settle;
  logic       scl_s;
  logic       armed;

  // Detection stays off until the synchronizers and history flops hold real
  // bus values, so releasing reset mid-transfer cannot fake a START or STOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
      settle <= 2'd3;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda_in};
      scl_d  <= scl_ff[1];
      sda_d  <= sda_ff[1];
      if (settle != 2'd0) settle <= settle - 2'd1;
    end
  end

  assign scl_s     = scl_ff[1];
  assign sda_s     = sda_ff[1];
  assign armed     = (settle == 2'd0);
  assign scl_rise  = armed &  scl_s & ~scl_d;
  assign scl_fall  = armed & ~scl_s &  scl_d;
  assign start_det = armed &  scl_s &  scl_d &  sda_d & ~sda_s;
  assign stop_det  = armed &  scl_s &  scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_slave.sv
// 7-bit address I2C slave with a write-byte sink and optional read source.
// Read support (TX states, tx_req) is built only when I2C_SLAVE_READ_EN is defined.
//
// state     | meaning
// IDLE      | bus free, or ignored until next START
// ADDR      | shifting address + R/W bit
// ADDR_ACK  | driving ACK for matched address
// RX        | shifting a write data byte
// RX_ACK    | driving ACK for accepted byte
// TX        | driving a read data byte
// TX_ACK    | sampling master ACK/NACK
// WAIT_STOP | SDA released, waiting for STOP or START
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = '1;

  logic                 sda_s;
  logic                 scl_rise;
  logic                 scl_fall;
  logic                 start_det;
  logic                 stop_det;
  i2c_state_e           state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [7:0]           shreg;
  logic                 addr_hit;

`ifdef I2C_SLAVE_READ_EN
  logic       rw;
  logic       mack;
  logic [7:0] tx_shift;
  assign addr_hit = (shreg[6:0] == SLAVE_ADDR);
`else
  logic unused_tx;
  assign unused_tx = ^tx_data;
  assign addr_hit  = (shreg[6:0] == SLAVE_ADDR) && (sda_s == 1'b0);
`endif

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda_in    (sda_in),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= 8'h00;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      rw       <= 1'b0;
      mack     <= 1'b0;
      tx_shift <= 8'h00;
`endif
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (stop_det) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (start_det) begin
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shreg   <= {shreg[6:0], sda_s};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
`ifdef I2C_SLAVE_READ_EN
              rw <= sda_s;
`endif
              state <= addr_hit ? ST_ADDR_ACK : ST_WAIT_STOP;
            end
          end
          // First SCL fall ends the 8th bit (drive ACK), second ends the ACK bit.
          ST_ADDR_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
`ifdef I2C_SLAVE_READ_EN
              if (rw) begin
                state  <= ST_TX;
                tx_req <= 1'b1;
              end else begin
                state <= ST_RX;
              end
`else
              state <= ST_RX;
`endif
            end
          end
          ST_RX: if (scl_rise) begin
            shreg   <= {shreg[6:0], sda_s};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              if (rx_ready) begin
                rx_data  <= {shreg[6:0], sda_s};
                rx_valid <= 1'b1;
                state    <= ST_RX_ACK;
              end else begin
                state <= ST_WAIT_STOP;
              end
            end
          end
          ST_RX_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_RX;
            end
          end
`ifdef I2C_SLAVE_READ_EN
          // tx_data is captured while tx_req is high; the MSB goes out right after.
          ST_TX: begin
            if (tx_req) begin
              tx_shift <= tx_data;
              sda_oe   <= ~tx_data[7];
            end else if (scl_fall) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                sda_oe <= 1'b0;
                mack   <= 1'b0;
                state  <= ST_TX_ACK;
              end else begin
                tx_shift <= {tx_shift[6:0], 1'b0};
                sda_oe   <= ~tx_shift[6];
              end
            end
          end
          ST_TX_ACK: begin
            if (scl_rise) begin
              if (sda_s == I2C_NACK) state <= ST_WAIT_STOP;
              else mack <= (sda_s == I2C_ACK);
            end else if (scl_fall && mack) begin
              tx_req  <= 1'b1;
              bit_cnt <= '0;
              state   <= ST_TX;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
